// File: rtl/status_event_sched.sv
// Front-end for the status LED latch: round-robin event arbiter, programmable
// periodic clear generator and a single-line self-test sweep.
module status_event_sched #(
  parameter int NUM_REQ        = 4,
  parameter int LINES          = 16,
  parameter int DEFAULT_PERIOD = 9_999_999,
  parameter int SWEEP_STEP     = 4_999_999
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*$clog2(LINES)-1:0] req_line,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           period_load,
  input  logic [31:0]                    period_value,
  input  logic                           sweep_start,
  output logic                           sweep_busy,
  output logic [LINES-1:0]               status_out,
  output logic                           clear_out
);
  localparam int W  = $clog2(LINES);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = $clog2(LINES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] SWEEP = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [31:0]      period;
  logic [31:0]      cnt;
  logic [IW-1:0]    sw_idx;
  logic [31:0]      sw_step;

  logic             found;
  logic [PW-1:0]    gnt_idx;
  logic             grant;
  logic [W-1:0]     gnt_line;
  logic [LINES-1:0] gnt_hot;
  logic [LINES-1:0] sw_hot;

  // First valid client at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [PW-1:0] j;
      j = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        gnt_idx = j;
      end
    end
  end

  // sweep_start outranks a grant in RUN, so the request stays pending.
  assign grant      = (state == RUN) && !sweep_start && found;
  assign req_ready  = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign gnt_line   = req_line[int'(gnt_idx)*W +: W];
  assign gnt_hot    = (int'(gnt_line) < LINES) ? (LINES'(1) << gnt_line) : '0;
  assign sw_hot     = LINES'(1) << sw_idx;
  assign sweep_busy = (state == SWEEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      period     <= 32'(DEFAULT_PERIOD);
      cnt        <= '0;
      sw_idx     <= '0;
      sw_step    <= '0;
      status_out <= '0;
      clear_out  <= 1'b0;
    end else begin
      status_out <= '0;
      clear_out  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sweep_start) begin
            state   <= SWEEP;
            sw_idx  <= '0;
            sw_step <= '0;
          end else if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (sweep_start) begin
            state   <= SWEEP;
            sw_idx  <= '0;
            sw_step <= '0;
          end else begin
            if (grant) begin
              status_out <= gnt_hot;
              ptr        <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (!enable) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == period) begin
              clear_out <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SWEEP: begin
          // Counter is frozen here; the extra idx==LINES pass gives the blank cycle.
          if (int'(sw_idx) < LINES) begin
            status_out <= sw_hot;
            if (sw_step == 32'(SWEEP_STEP)) begin
              sw_step <= '0;
              sw_idx  <= sw_idx + 1'b1;
            end else begin
              sw_step <= sw_step + 1'b1;
            end
          end else begin
            state <= enable ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (period_load) begin
        period    <= period_value;
        cnt       <= '0;
        clear_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_status_event_sched.sv
// Directed bench for status_event_sched: arbitration order, clear period,
// sweep sequencing, out-of-range lines and reset recovery.
module tb_status_event_sched;
  localparam int NUM_REQ = 4;
  localparam int LINES   = 20;
  localparam int W       = $clog2(LINES);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*W-1:0]   req_line;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   period_load;
  logic [31:0]            period_value;
  logic                   sweep_start;
  logic                   sweep_busy;
  logic [LINES-1:0]       status_out;
  logic                   clear_out;

  int n_tests = 0;
  int n_fail  = 0;
  int ln[4]   = '{3, 5, 9, 12};

  status_event_sched #(
    .NUM_REQ(NUM_REQ), .LINES(LINES), .DEFAULT_PERIOD(19), .SWEEP_STEP(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_line(req_line), .req_ready(req_ready),
    .period_load(period_load), .period_value(period_value),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .status_out(status_out), .clear_out(clear_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = '0;
    req_line = {5'd12, 5'd9, 5'd5, 5'd3};
    period_load = 1'b0; period_value = '0; sweep_start = 1'b0;
    tick; tick;
    chk("rst_status", 32'(status_out), 0);
    chk("rst_clear",  32'(clear_out),  0);
    chk("rst_ready",  32'(req_ready),  0);
    chk("rst_busy",   32'(sweep_busy), 0);

    // Two clients alternate.
    reset = 1'b0; enable = 1'b1; req_valid = 4'b0101; #1;
    chk("idle_ready", 32'(req_ready), 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("alt_ready", 32'(req_ready), (i % 2) ? 32'h4 : 32'h1);
      tick;
      chk("alt_status", 32'(status_out), (i % 2) ? 32'h200 : 32'h8);
    end

    // Pointer is at 3; grant client 3 to bring it back to 0.
    req_valid = 4'b1000; #1;
    chk("c3_ready", 32'(req_ready), 32'h8);
    tick;
    chk("c3_status", 32'(status_out), 32'h1000);

    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("all_ready", 32'(req_ready), 32'(1) << (i % 4));
      tick;
      chk("all_status", 32'(status_out), 32'(1) << ln[i % 4]);
    end
    req_valid = '0;
    tick;

    // Period 4: pulse every 5 cycles.
    period_value = 32'd4; period_load = 1'b1;
    tick;
    period_load = 1'b0;
    chk("load_noclr", 32'(clear_out), 0);
    for (int k = 1; k <= 10; k++) begin
      tick;
      chk("per4_clear", 32'(clear_out), (k % 5 == 0) ? 1 : 0);
    end
    period_value = 32'd0; period_load = 1'b1;
    tick;
    period_load = 1'b0;
    chk("load0_noclr", 32'(clear_out), 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("per0_clear", 32'(clear_out), 1);
    end

    // Out-of-range line is granted but discarded.
    req_line = {5'd20, 5'd9, 5'd5, 5'd3}; req_valid = 4'b1000; #1;
    chk("oor_ready", 32'(req_ready), 32'h8);
    tick;
    chk("oor_status", 32'(status_out), 0);
    req_line = {5'd12, 5'd9, 5'd5, 5'd3};

    // Sweep with client 1 pending.
    req_valid = 4'b0010; sweep_start = 1'b1; #1;
    chk("swst_ready", 32'(req_ready), 0);
    tick;
    sweep_start = 1'b0;
    chk("sw_busy0",   32'(sweep_busy), 1);
    chk("sw_status0", 32'(status_out), 0);
    chk("sw_clear0",  32'(clear_out),  0);
    for (int idx = 0; idx < LINES; idx++) begin
      for (int s = 0; s < 2; s++) begin
        tick;
        chk("sw_status", 32'(status_out), 32'(1) << idx);
        chk("sw_ready",  32'(req_ready),  0);
        chk("sw_clear",  32'(clear_out),  0);
        chk("sw_busy",   32'(sweep_busy), 1);
      end
    end
    tick;
    chk("swend_status", 32'(status_out), 0);
    chk("swend_busy",   32'(sweep_busy), 0);
    chk("swend_ready",  32'(req_ready),  32'h2);
    tick;
    chk("swend_grant", 32'(status_out), 32'h20);
    req_valid = '0;

    // Reset during sweep index 5.
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    repeat (11) tick;
    chk("sw5_status", 32'(status_out), 32'h20);
    req_valid = 4'b1111; reset = 1'b1;
    tick;
    chk("rsw_status", 32'(status_out), 0);
    chk("rsw_clear",  32'(clear_out),  0);
    chk("rsw_busy",   32'(sweep_busy), 0);
    chk("rsw_ready",  32'(req_ready),  0);

    // Period 4 loaded, then reset restores the default of 19.
    reset = 1'b0; enable = 1'b0; req_valid = '0;
    period_value = 32'd4; period_load = 1'b1;
    tick;
    period_load = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0; enable = 1'b1;
    tick;
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk("rst_period", 32'(clear_out), (k == 20) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/status_event_sched.md
Name: status_event_sched

Overview:
- Front-end controller for the 16-bit status LED latch.
- Shares the latch's `status` inputs between NUM_REQ independent requesters via round-robin arbitration, one event per cycle.
- Generates the periodic `clear` pulse with a run-time programmable period.
- Provides a self-test sweep that walks a single lit line across all LEDs.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- LINES, 16, number of status lines driven.
- DEFAULT_PERIOD, 9_999_999, clear period after reset; clear fires every DEFAULT_PERIOD+1 cycles.
- SWEEP_STEP, 4_999_999, cycles each line is pulsed-held during the sweep, minus 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- enable  in  1  1 = run arbiter and clear timer; 0 = idle.
- req_valid  in  NUM_REQ  per-client event request.
- req_line  in  NUM_REQ*$clog2(LINES)  per-client line index, client k at bits [k*W +: W].
- req_ready  out  NUM_REQ  one-hot grant, asserted in the accept cycle.
- period_load  in  1  one-cycle strobe: load period_value.
- period_value  in  32  new clear period minus 1.
- sweep_start  in  1  one-cycle strobe: begin LED sweep.
- sweep_busy  out  1  high while sweeping.
- status_out  out  LINES  to LED latch status, registered.
- clear_out  out  1  to LED latch clear, registered, one-cycle pulse.

Behaviour:
- Reset values:
  - Outputs: status_out=0, clear_out=0, req_ready=0, sweep_busy=0.
  - Internal: state=IDLE, period register=DEFAULT_PERIOD, clear counter=0, round-robin pointer=0 (client 0 highest priority).
- States:
  - IDLE:
    - req_ready=0, counter held at 0, status_out=0, clear_out=0.
    - enable=1 → RUN.
    - sweep_start → SWEEP; sweep_start takes effect regardless of enable.
  - RUN:
    - Arbitration: among asserted req_valid, grant the first client at or after the pointer (wrapping). req_ready is combinational from req_valid and the pointer, and is one-hot or zero.
    - On grant k:
      - Next cycle status_out = one-hot of req_line[k]; all other bits 0. Latency is 1 cycle.
      - Pointer ← k+1 mod NUM_REQ.
      - No grant → pointer unchanged.
    - req_line ≥ LINES: accepted but discarded; status_out=0 that cycle.
    - Clear timer:
      - Counter increments each cycle.
      - When counter == period: clear_out=1 next cycle and counter ← 0.
      - period=0 → clear_out continuously high.
    - Status and clear pulses in the same cycle are legal; the latch gives status priority.
    - enable=0 → IDLE after the current cycle; counter cleared.
    - sweep_start → SWEEP; sweep_start has priority over grant in that cycle.
  - SWEEP:
    - req_ready=0 (requests stall and are not lost), clear timer frozen, clear_out=0.
    - status_out is one-hot on the sweep index for SWEEP_STEP+1 cycles per index, index 0..LINES-1.
    - After the last index, status_out=0 for one cycle, then return to RUN if enable else IDLE.
    - Counter resumes from its frozen value.
    - sweep_busy=1 exactly while in SWEEP.
    - sweep_start during SWEEP is ignored.
- period_load:
  - Accepted in any state.
  - Period ← period_value; counter ← 0 in the same cycle. No clear pulse is produced by the load itself.
  - If the terminal count coincides with period_load, the load wins and no pulse is produced.
- Reset mid-sweep or mid-grant: all state returns to reset values on the next edge; a pending status_out pulse is dropped.
- Counter width: 32 bits, unsigned compare, no overflow since it is reset at the period.

Test Plan:
- Reset, enable=1, clients 0 and 2 hold valid with lines 3 and 9 → grants alternate 0,2,0,2; status_out alternates 0x0008, 0x0200, each 1 cycle after grant.
- All 4 clients valid continuously for 8 cycles → each client granted exactly twice, in order 0,1,2,3,0,1,2,3; req_ready always one-hot.
- period_load with value 4, no requests → clear_out pulses every 5 cycles. Then reload with 0 → clear_out stays high.
- sweep_start with SWEEP_STEP=1 while client 1 valid → status_out steps 0x0001, 0x0002 … 0x8000 (2 cycles each); req_ready=0 throughout. Client 1 is granted on the first RUN cycle after sweep_busy falls, and clear_out never pulses during the sweep.
- req_line=20 from client 3 → req_ready[3]=1 and status_out=0 next cycle.
- Reset asserted during sweep index 5 → next cycle all outputs 0 and state IDLE. Reset asserted with period loaded at 4 → next cycle period restores to DEFAULT_PERIOD.
